kfps2kb_command_scheduler: RTL

//  Host-side command sequencer for the PS/2 keyboard link. Arbitrates reset and LED-update requests,

---
 rtl/kfps2kb_command_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/kfps2kb_command_scheduler.sv
// Host-side PS/2 keyboard command sequencer: arbitrates reset/LED (and optionally typematic) requests,
// drives the host-to-device transmitter and tracks ACK/resend/BAT replies. Option macro: KFPS2KB_TYPEMATIC_EN.
module kfps2kb_command_scheduler #(
  parameter logic [23:0] ACK_TIMEOUT = 24'd20000,
  parameter logic [23:0] BAT_TIMEOUT = 24'd1000000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_reset,
  input  logic       req_leds,
  input  logic [2:0] led_state,
`ifdef KFPS2KB_TYPEMATIC_EN
  input  logic       req_typematic,
  input  logic [7:0] typematic_rate,
`endif
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       tx_done,
  input  logic       tx_error,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_claim,
  output logic       busy,
  output logic       bat_pass,
  output logic       cmd_error
);

  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_LEDS  = 8'hED;
  localparam logic [7:0] CMD_TYPE  = 8'hF3;
  localparam logic [7:0] RSP_ACK   = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_WAIT_BAT, S_RETRY
  } state_t;

  typedef enum logic [1:0] {C_RESET, C_LEDS, C_TYPE} cmd_t;

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  arg_q, arg_d;
  logic        is_arg_q, is_arg_d;
  logic [1:0]  retry_q, retry_d;
  logic [23:0] timer_q, timer_d;
  logic        cmd_error_q, cmd_error_d;
  logic        pend_reset_q, pend_reset_d;
  logic        pend_leds_q, pend_leds_d;
  logic        pend_type_q, pend_type_d;

  logic        req_type_w;
  logic [7:0]  type_rate_w;
  logic [23:0] timer_inc;

`ifdef KFPS2KB_TYPEMATIC_EN
  assign req_type_w  = req_typematic;
  assign type_rate_w = typematic_rate;
`else
  assign req_type_w  = 1'b0;
  assign type_rate_w = 8'h00;
`endif

  assign timer_inc = (timer_q == 24'hFFFFFF) ? timer_q : timer_q + 24'd1;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    tx_data_d   = tx_data_q;
    arg_d       = arg_q;
    is_arg_d    = is_arg_q;
    retry_d     = retry_q;
    timer_d     = '0;
    cmd_error_d = cmd_error_q;
    pend_reset_d = pend_reset_q | req_reset;
    pend_leds_d  = pend_leds_q | req_leds;
    pend_type_d  = pend_type_q | req_type_w;
    rx_claim    = 1'b0;
    bat_pass    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_reset_q || pend_leds_q || pend_type_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        cmd_error_d = 1'b0;
        retry_d     = 2'd0;
        is_arg_d    = 1'b0;
        state_d     = S_SEND;
        // A reset returns the device LEDs to off, so a queued LED update is dropped.
        // Requests arriving this very cycle still latch and are serviced afterwards.
        if (pend_reset_q) begin
          cmd_d        = C_RESET;
          tx_data_d    = CMD_RESET;
          pend_reset_d = req_reset;
          pend_leds_d  = req_leds;
        end else if (pend_leds_q) begin
          cmd_d       = C_LEDS;
          tx_data_d   = CMD_LEDS;
          arg_d       = {5'b0, led_state};
          pend_leds_d = req_leds;
        end else if (pend_type_q) begin
          cmd_d       = C_TYPE;
          tx_data_d   = CMD_TYPE;
          arg_d       = type_rate_w;
          pend_type_d = req_type_w;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (tx_ready) state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done) state_d = S_WAIT_ACK;
        else if (tx_error) state_d = S_RETRY;
      end
      S_WAIT_ACK: begin
        timer_d = timer_inc;
        // A received byte takes precedence over a timeout in the same cycle.
        if (rx_valid && rx_data == RSP_ACK) begin
          rx_claim = 1'b1;
          if (cmd_q == C_RESET) begin
            state_d = S_WAIT_BAT;
            timer_d = '0;
          end else if (!is_arg_q) begin
            tx_data_d = arg_q;
            is_arg_d  = 1'b1;
            retry_d   = 2'd0;
            state_d   = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end else if (rx_valid && rx_data == RSP_RESEND) begin
          rx_claim = 1'b1;
          state_d  = S_RETRY;
        end else if (timer_q >= ACK_TIMEOUT - 24'd1) begin
          state_d = S_RETRY;
        end
      end
      S_WAIT_BAT: begin
        timer_d = timer_inc;
        if (rx_valid && rx_data == RSP_BAT_OK) begin
          rx_claim = 1'b1;
          bat_pass = 1'b1;
          state_d  = S_IDLE;
        end else if (rx_valid && rx_data == RSP_BAT_ERR) begin
          rx_claim    = 1'b1;
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end else if (timer_q >= BAT_TIMEOUT - 24'd1) begin
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_RETRY: begin
        if (retry_q == MAX_RETRY) begin
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          retry_d = retry_q + 2'd1;
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= C_RESET;
      tx_data_q    <= 8'h00;
      arg_q        <= 8'h00;
      is_arg_q     <= 1'b0;
      retry_q      <= 2'd0;
      timer_q      <= 24'd0;
      cmd_error_q  <= 1'b0;
      pend_reset_q <= 1'b0;
      pend_leds_q  <= 1'b0;
      pend_type_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      tx_data_q    <= tx_data_d;
      arg_q        <= arg_d;
      is_arg_q     <= is_arg_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      cmd_error_q  <= cmd_error_d;
      pend_reset_q <= pend_reset_d;
      pend_leds_q  <= pend_leds_d;
      pend_type_q  <= pend_type_d;
    end
  end

  assign tx_valid  = (state_q == S_SEND);
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != S_IDLE);
  assign cmd_error = cmd_error_q;

endmodule
